// File: rtl/my_stream_fifo.sv
// Purpose : valid/ready streaming FIFO, DEPTH x DATA_WIDTH register array, in-order delivery.
// Latency : 1 cycle write-to-read; out_data is a combinational read of the head entry.
// Backpressure: in_ready = !full (a pop cannot make room for a push in the same cycle);
//               out_valid = !empty. Status flags decode only from the registered count.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready/in_data upstream channel
//   out_valid/out_ready/out_data downstream channel (head word)
//   count, full, empty, almost_full  occupancy status (registered-derived)
//   max_count                 peak occupancy since reset; only with MY_STREAM_FIFO_STATS_EN
//
// Optional feature macro: MY_STREAM_FIFO_STATS_EN
module my_stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AFULL_TH   = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
`ifdef MY_STREAM_FIFO_STATS_EN
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  max_count
`else
    output logic                    almost_full
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;
    logic                  push;
    logic                  pop;

    // Flags come only from the registered count, so no input reaches an output combinationally.
    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= AFULL_C);
    assign count       = count_q;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = mem_q[rd_ptr_q];

    // A handshake during the reset cycle must leave no trace, including in memory.
    assign push = in_valid  && in_ready  && !rst;
    assign pop  = out_valid && out_ready && !rst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are exactly AW bits wide, so DEPTH-1 -> 0 wraps for free.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            // The handshake rules keep count within 0..DEPTH; no clamping needed.
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    // Storage is intentionally not reset; stale entries are unobservable behind out_valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef MY_STREAM_FIFO_STATS_EN
    logic [CW-1:0] max_count_q, max_count_d;

    // Tracks against the next count so the peak is visible right after the edge that reaches it.
    always_comb begin
        max_count_d = max_count_q;
        if (rst)                       max_count_d = '0;
        else if (count_d > max_count_q) max_count_d = count_d;
    end

    always_ff @(posedge clk) begin
        max_count_q <= max_count_d;
    end

    assign max_count = max_count_q;
`endif

endmodule

// File: tb/tb_my_stream_fifo.sv
module tb_my_stream_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF_TH = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [4:0]    count;
    logic          full;
    logic          empty;
    logic          almost_full;
`ifdef MY_STREAM_FIFO_STATS_EN
    logic [4:0]    max_count;
    int            mmax;
`endif

    int errs   = 0;
    int checks = 0;

    // Reference model: the buffered words, oldest first.
    logic [DW-1:0] mq[$];

    always #5 clk = ~clk;

    my_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_TH(AF_TH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
`ifdef MY_STREAM_FIFO_STATS_EN
        .almost_full (almost_full),
        .max_count   (max_count)
`else
        .almost_full (almost_full)
`endif
    );

    // One clock edge: update the model from the inputs presented at that edge,
    // then step 1 time unit past the edge so outputs can be sampled and inputs changed.
    task automatic tick();
        int n;
        bit pu;
        bit po;
        @(posedge clk);
        n = mq.size();
        if (rst) begin
            mq.delete();
`ifdef MY_STREAM_FIFO_STATS_EN
            mmax = 0;
`endif
        end else begin
            pu = in_valid && (n != DEPTH);
            po = out_ready && (n != 0);
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back(in_data);
`ifdef MY_STREAM_FIFO_STATS_EN
            if (mq.size() > mmax) mmax = mq.size();
`endif
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++; if (count !== 5'd0) begin errs++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (full !== 1'b0) begin errs++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (almost_full !== 1'b0) begin errs++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
`ifdef MY_STREAM_FIFO_STATS_EN
        checks++; if (max_count !== 5'd0) begin errs++; $display("FAIL reset_max_count got=%0d exp=0", max_count); end
`endif
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            tick();
            checks++; if (count !== 5'(i)) begin errs++; $display("FAIL fill_count push=%0d got=%0d exp=%0d", i, count, i); end
            checks++; if (almost_full !== (i >= 12)) begin errs++; $display("FAIL fill_almost_full push=%0d got=%b exp=%b", i, almost_full, i >= 12); end
            checks++; if (full !== (i == 16)) begin errs++; $display("FAIL fill_full push=%0d got=%b exp=%b", i, full, i == 16); end
            checks++; if (in_ready !== (i != 16)) begin errs++; $display("FAIL fill_in_ready push=%0d got=%b exp=%b", i, in_ready, i != 16); end
        end
        in_data = 8'hAA;
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 5'd16) begin errs++; $display("FAIL fill_overflow_count got=%0d exp=16", count); end
        checks++; if (out_data !== 8'h01) begin errs++; $display("FAIL fill_head got=%h exp=01", out_data); end
    endtask

    task automatic test_drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== DW'(i)) begin
                errs++; $display("FAIL drain_order idx=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, DW'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errs++; $display("FAIL drain_empty got=%b exp=1", empty); end
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL drain_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_simul();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h60 + DW'(i);
            tick();
        end
        in_data   = 8'h55;
        out_ready = 1'b1;
        tick();
        checks++; if (count !== 5'd5) begin errs++; $display("FAIL simul_count got=%0d exp=5", count); end
        checks++; if (out_data !== 8'h61) begin errs++; $display("FAIL simul_head got=%h exp=61", out_data); end
        // Keep streaming well past a full pointer lap.
        for (int i = 0; i < 20; i++) begin
            in_data = DW'($urandom);
            tick();
            checks++; if (count !== 5'd5 || out_data !== mq[0]) begin
                errs++; $display("FAIL simul_stream cyc=%0d got=%0d/%h exp=5/%h", i, count, out_data, mq[0]);
            end
        end
        in_valid = 1'b0;
        while (mq.size() != 0) begin
            checks++; if (out_valid !== 1'b1 || out_data !== mq[0]) begin
                errs++; $display("FAIL simul_drain got=%b/%h exp=1/%h", out_valid, out_data, mq[0]);
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] second;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_data = DW'($urandom);
            tick();
        end
        checks++; if (full !== 1'b1) begin errs++; $display("FAIL fullpop_full got=%b exp=1", full); end
        second    = mq[1];
        in_data   = 8'h77;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (count !== 5'd15) begin errs++; $display("FAIL fullpop_count got=%0d exp=15", count); end
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL fullpop_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== second) begin errs++; $display("FAIL fullpop_head got=%h exp=%h", out_data, second); end
        out_ready = 1'b1;
        while (mq.size() != 0) begin
            checks++; if (out_data !== mq[0]) begin errs++; $display("FAIL fullpop_drain got=%h exp=%h", out_data, mq[0]); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errs++; $display("FAIL fullpop_empty got=%b exp=1", empty); end
    endtask

    task automatic test_random();
        int pv;
        int pr;
        for (int i = 0; i < 800; i++) begin
            // Alternate producer-heavy and consumer-heavy phases to visit full and empty.
            pv = ((i / 100) % 2 == 0) ? 80 : 30;
            pr = ((i / 100) % 2 == 0) ? 30 : 80;
            in_valid  = ($urandom_range(0, 99) < pv);
            out_ready = ($urandom_range(0, 99) < pr);
            in_data   = DW'($urandom);
            tick();
            checks++; if (count !== mq.size()) begin errs++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", i, count, mq.size()); end
            checks++; if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() != DEPTH)) begin
                errs++; $display("FAIL rand_hs cyc=%0d got=%b%b exp=%b%b", i, out_valid, in_ready, mq.size() != 0, mq.size() != DEPTH);
            end
            checks++; if (full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) || almost_full !== (mq.size() >= AF_TH)) begin
                errs++; $display("FAIL rand_flags cyc=%0d got=%b%b%b size=%0d", i, full, empty, almost_full, mq.size());
            end
            if (mq.size() != 0) begin
                checks++; if (out_data !== mq[0]) begin errs++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, out_data, mq[0]); end
            end
`ifdef MY_STREAM_FIFO_STATS_EN
            checks++; if (max_count !== 5'(mmax)) begin errs++; $display("FAIL rand_max cyc=%0d got=%0d exp=%0d", i, max_count, mmax); end
`endif
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_midreset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_data = 8'h90 + DW'(i);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0;
        checks++; if (count !== 5'd5) begin errs++; $display("FAIL mid_count got=%0d exp=5", count); end
        checks++; if (out_data !== 8'h94) begin errs++; $display("FAIL mid_head got=%h exp=94", out_data); end
`ifdef MY_STREAM_FIFO_STATS_EN
        checks++; if (max_count !== 5'd9) begin errs++; $display("FAIL mid_max got=%0d exp=9", max_count); end
`endif
        // Handshakes in the reset cycle must be ignored.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (count !== 5'd0) begin errs++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0 || empty !== 1'b1) begin errs++; $display("FAIL mid_rst_flags got=%b%b exp=01", out_valid, empty); end
`ifdef MY_STREAM_FIFO_STATS_EN
        checks++; if (max_count !== 5'd0) begin errs++; $display("FAIL mid_rst_max got=%0d exp=0", max_count); end
`endif
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
            errs++; $display("FAIL mid_post_push got=%b/%h exp=1/3c", out_valid, out_data);
        end
        checks++; if (count !== 5'd1) begin errs++; $display("FAIL mid_post_count got=%0d exp=1", count); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef MY_STREAM_FIFO_STATS_EN
        mmax = 0;
`endif
        test_reset();
        test_fill();
        test_drain();
        test_simul();
        test_full_pop();
        test_random();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
